mem_access: RTL
===============

Name: mem_access

Overview:
- Memory stage of the RISC-V pipeline. It sits between execute and the writeback stage and produces the record that writeback consumes (wa/we/wdata/dmemen/dmemwe/LD_sel/dmemdata).
- Registers each execute result and drives data-memory requests with byte-lane alignment.
- Waits for load data and merges it, sign- or zero-extended, into wdata_o. Stalls execute while a memory access is in flight.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles waiting for dmem_rvalid_i before aborting with bus error; range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ex_valid_i  in  1  execute record valid
- ex_ready_o  out  1  stage can accept a record this cycle
- ex_wa_i  in  5  destination register
- ex_we_i  in  1  register write enable
- ex_result_i  in  32  ALU result; effective address for load/store
- ex_store_data_i  in  32  rs2 value for stores
- ex_load_i  in  1  load instruction
- ex_store_i  in  1  store instruction
- ex_funct3_i  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- dmem_req_o  out  1  memory request strobe, one cycle
- dmem_we_o  out  4  byte write enables, 0 for reads
- dmem_addr_o  out  32  word-aligned address (bits 1:0 = 0)
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_rdata_i  in  32  read data
- dmem_rvalid_i  in  1  response/ack for reads and writes
- wb_valid_o  out  1  writeback record valid
- wa_o  out  5  to writeback
- we_o  out  1  to writeback
- wdata_o  out  32  ALU result or extended load data
- dmemen_o  out  1  record carries a memory access
- dmemwe_o  out  4  byte enables of the completed access
- LD_sel_o  out  4  bit0 load merged; bit1 signed; bits3:2 size (00 B, 01 H, 10 W)
- dmemdata_o  out  32  aligned store data
- buserr_o  out  1  one-cycle pulse on timeout
- misalign_o  out  1  one-cycle pulse on misaligned access (only with MISALIGN_TRAP_EN)

Behaviour:
- Reset values:
  - All outputs are 0 except ex_ready_o, which is 1.
  - FSM returns to IDLE and the timeout counter clears.
  - Reset mid-access abandons the access; no wb_valid_o is produced for it.
- FSM states:
  - IDLE: ex_ready_o = 1.
    - Non-memory record accepted: the record is registered. Next cycle wb_valid_o = 1, wdata_o = ex_result_i, dmemen_o = 0, dmemwe_o = 0, LD_sel_o = 0. Latency 1, throughput 1/cycle.
    - Load or store accepted: dmem_req_o = 1 in the following cycle, with the address, byte enables and data registered. Go to WAIT.
  - WAIT: ex_ready_o = 0; the counter increments each cycle.
    - dmem_rvalid_i = 1: next cycle emit the record (wb_valid_o = 1) and go to IDLE.
    - Counter reaches TIMEOUT_CYCLES: next cycle pulse buserr_o, wb_valid_o = 1 with we_o = 0, go to IDLE.
    - dmem_rvalid_i in the same cycle as the timeout: the response wins.
  - dmem_rvalid_i while in IDLE is ignored.
- Byte enables, from addr[1:0]:
  - SB: 0001 << a.
  - SH: 0011 << (a[1]*2).
  - SW: 1111.
- Store data:
  - dmem_wdata_o replicates the byte or halfword across all lanes.
  - dmemdata_o = dmem_wdata_o.
- Stores:
  - dmem_we_o = enables.
  - Record carries dmemen_o = 1, dmemwe_o = enables, LD_sel_o[0] = 0, we_o = 0.
- Loads:
  - dmem_we_o = 0.
  - The lane is selected by addr[1:0] and extended per funct3.
  - Record carries wdata_o = extended data, dmemen_o = 1, dmemwe_o = 0, LD_sel_o[0] = 1, so writeback does not re-enable memory.
  - LD_sel_o[1] = 1 for B/H, 0 for BU/HU/W.
- Loads with ex_wa_i = 0 complete normally with we_o = 0.
- ex_valid_i = 0 in IDLE: wb_valid_o = 0 next cycle; the other outputs hold.
- ex_load_i and ex_store_i both 1: treated as a store.

Optional Feature:
- MISALIGN_TRAP_EN, defined:
  - Halfword access with a[0] = 1, or word access with a[1:0] != 0, issues no memory request.
  - Next cycle: misalign_o pulses, wb_valid_o = 1 with we_o = 0, dmemen_o = 0. Stays in IDLE.
- MISALIGN_TRAP_EN, undefined:
  - Low address bits are forced to natural alignment: H clears a[0], W clears a[1:0].
  - misalign_o is tied to 0.

Test Plan:
- Reset then ALU op: wa = 5, result = 0x1234 -> one cycle later wb_valid_o = 1, wa_o = 5, wdata_o = 0x1234, dmemen_o = 0; ex_ready_o stays 1.
- SB, addr = 0x103, data = 0xAB, rvalid after 2 cycles -> dmem_we_o = 1000, dmem_wdata_o = 0xABABABAB, dmem_addr_o = 0x100; record dmemwe_o = 1000; ex_ready_o low for 3 cycles.
- LB, addr = 0x202, rdata = 0x00800000 -> wdata_o = 0xFFFFFF80, LD_sel_o = 0011. LBU, same stimulus -> wdata_o = 0x00000080, LD_sel_o = 0001.
- LH, addr = 0x2, rdata = 0x8001_0000 -> wdata_o = 0xFFFF8001, LD_sel_o = 0111. LW -> wdata_o = rdata, LD_sel_o = 1001.
- Load with no rvalid -> buserr_o pulses after 16 WAIT cycles, record we_o = 0, FSM back to IDLE. Assert rst_i during WAIT -> no record, ex_ready_o = 1.
- LW at 0x6:
  - with MISALIGN_TRAP_EN: misalign_o pulses, no dmem_req_o.
  - without it: request at 0x4.

Source files
------------

// File: rtl/mem_access.sv
// Memory stage: registers execute results, issues aligned data-memory requests, merges load data.
// Optional MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing natural alignment.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_wa_i,
    input  logic        ex_we_i,
    input  logic [31:0] ex_result_i,
    input  logic [31:0] ex_store_data_i,
    input  logic        ex_load_i,
    input  logic        ex_store_i,
    input  logic [2:0]  ex_funct3_i,
    output logic        dmem_req_o,
    output logic [3:0]  dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_rvalid_i,
    output logic        wb_valid_o,
    output logic [4:0]  wa_o,
    output logic        we_o,
    output logic [31:0] wdata_o,
    output logic        dmemen_o,
    output logic [3:0]  dmemwe_o,
    output logic [3:0]  LD_sel_o,
    output logic [31:0] dmemdata_o,
    output logic        buserr_o,
    output logic        misalign_o
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q;
    logic [7:0]  cnt_q;

    // Request side
    logic        req_q;
    logic [3:0]  dmem_we_q;
    logic [31:0] dmem_addr_q;
    logic [31:0] dmem_wdata_q;

    // Pending access context held across WAIT
    logic [4:0]  rec_wa_q;
    logic        rec_we_q;
    logic        load_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] result_q;

    // Writeback record
    logic        wb_valid_q;
    logic [4:0]  wa_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        dmemen_q;
    logic [3:0]  dmemwe_q;
    logic [3:0]  ld_sel_q;
    logic [31:0] dmemdata_q;
    logic        buserr_q;
    logic        misalign_q;

    logic        is_mem;
    logic        is_load;
    logic        trap;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic        timeout;

    assign is_mem  = ex_load_i | ex_store_i;
    assign is_load = ex_load_i & ~ex_store_i;
    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        size = ex_funct3_i[1] ? 2'b10 : {1'b0, ex_funct3_i[0]};
        lane = ex_result_i[1:0];
        if (size == 2'b01) begin
            lane[0] = 1'b0;
        end else if (size == 2'b10) begin
            lane = 2'b00;
        end
        case (size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{ex_store_data_i[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << lane;
                wrep = {2{ex_store_data_i[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = ex_store_data_i;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = is_mem && (((size == 2'b01) && ex_result_i[0]) ||
                             ((size == 2'b10) && (ex_result_i[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        case (lane_q)
            2'd0:    lane_half = dmem_rdata_i[15:0];
            2'd1:    lane_half = dmem_rdata_i[23:8];
            2'd2:    lane_half = dmem_rdata_i[31:16];
            default: lane_half = {8'h00, dmem_rdata_i[31:24]};
        endcase
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane_half[7]}}, lane_half[7:0]};
            2'b01:   load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            dmem_we_q    <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            rec_wa_q     <= '0;
            rec_we_q     <= 1'b0;
            load_q       <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            lane_q       <= '0;
            result_q     <= '0;
            wb_valid_q   <= 1'b0;
            wa_q         <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            dmemen_q     <= 1'b0;
            dmemwe_q     <= '0;
            ld_sel_q     <= '0;
            dmemdata_q   <= '0;
            buserr_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            buserr_q   <= 1'b0;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid_i) begin
                        if (!is_mem || trap) begin
                            wb_valid_q <= 1'b1;
                            wa_q       <= ex_wa_i;
                            we_q       <= ex_we_i & ~trap;
                            wdata_q    <= ex_result_i;
                            dmemen_q   <= 1'b0;
                            dmemwe_q   <= '0;
                            ld_sel_q   <= '0;
                            dmemdata_q <= '0;
                            misalign_q <= trap;
                        end else begin
                            req_q        <= 1'b1;
                            dmem_addr_q  <= {ex_result_i[31:2], 2'b00};
                            dmem_we_q    <= is_load ? 4'b0000 : be;
                            dmem_wdata_q <= wrep;
                            rec_wa_q     <= ex_wa_i;
                            rec_we_q     <= is_load & ex_we_i & (ex_wa_i != 5'd0);
                            load_q       <= is_load;
                            signed_q     <= ~ex_funct3_i[2] & ~ex_funct3_i[1];
                            size_q       <= size;
                            lane_q       <= lane;
                            result_q     <= ex_result_i;
                            cnt_q        <= '0;
                            state_q      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A response in the timeout cycle still completes normally.
                    if (dmem_rvalid_i || timeout) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b1;
                        wa_q       <= rec_wa_q;
                        we_q       <= dmem_rvalid_i & rec_we_q;
                        buserr_q   <= ~dmem_rvalid_i;
                        dmemen_q   <= 1'b1;
                        dmemwe_q   <= dmem_we_q;
                        dmemdata_q <= dmem_wdata_q;
                        ld_sel_q   <= load_q ? {size_q, signed_q, 1'b1} : 4'b0000;
                        if (!load_q) begin
                            wdata_q <= result_q;
                        end else if (dmem_rvalid_i) begin
                            wdata_q <= load_ext;
                        end else begin
                            wdata_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ex_ready_o   = (state_q == ST_IDLE);
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wa_o         = wa_q;
    assign we_o         = we_q;
    assign wdata_o      = wdata_q;
    assign dmemen_o     = dmemen_q;
    assign dmemwe_o     = dmemwe_q;
    assign LD_sel_o     = ld_sel_q;
    assign dmemdata_o   = dmemdata_q;
    assign buserr_o     = buserr_q;
    assign misalign_o   = misalign_q;

endmodule
